dsss_tx_sequencer: RTL and testbench

Frame-level transmit controller for the DSSS chain. It runs on the fast carrier-sample clock and generates the chip-rate strobe. It sequences a preamble and then a payload of data bits. Each bit is spread with a 15-chip PN sequence and drives the resulting chip stream into the BPSK modulator's data input, with a modulator enable.

---
 rtl/dsss_tx_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_dsss_tx_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dsss_tx_sequencer.sv
// DSSS frame transmit sequencer: preamble + payload bits spread by a 15-chip PN code.
// Optional abort input/aborted pulse enabled by defining DSSS_TX_ABORT_EN.
module dsss_tx_sequencer #(
    parameter int unsigned CHIP_DIV      = 250,
    parameter int unsigned CHIPS_PER_BIT = 15,
    parameter int unsigned PREAMBLE_BITS = 8,
    parameter int unsigned LEN_W         = 8,
    parameter logic [3:0]  PN_SEED       = 4'b0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             bit_data,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic             chip_out,
    output logic             chip_stb,
    output logic             mod_en,
    output logic             busy,
    output logic             done,
    output logic             underrun
`ifdef DSSS_TX_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    localparam int unsigned DIV_W = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam int unsigned IDX_W = (CHIPS_PER_BIT > 1) ? $clog2(CHIPS_PER_BIT) : 1;
    localparam int unsigned CNT_W = (LEN_W > 8) ? LEN_W : 8;
    localparam int unsigned FET_W = LEN_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_DONE} state_t;

    state_t             state, state_d;
    logic [DIV_W-1:0]   chip_cnt, chip_cnt_d;
    logic [IDX_W-1:0]   chip_idx, chip_idx_d;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_d, bit_nxt;
    logic [LEN_W-1:0]   len, len_d;
    logic [FET_W-1:0]   fetched, fetched_d;
    logic [3:0]         lfsr, lfsr_d;
    logic               hold_full, hold_full_d, hold_bit, hold_bit_d;
    logic               cur_bit, cur_bit_d, underrun_d;
    logic               consume, xfer, active_d, abort_hit;

    always_comb begin
        state_d     = state;
        chip_cnt_d  = chip_cnt;
        chip_idx_d  = chip_idx;
        bit_cnt_d   = bit_cnt;
        len_d       = len;
        fetched_d   = fetched;
        lfsr_d      = lfsr;
        hold_full_d = hold_full;
        hold_bit_d  = hold_bit;
        cur_bit_d   = cur_bit;
        underrun_d  = underrun;
        consume     = 1'b0;
        abort_hit   = 1'b0;
        xfer        = bit_valid && bit_ready;
        bit_nxt     = bit_cnt + CNT_W'(1);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_PREAMBLE;
                    len_d       = frame_len;
                    underrun_d  = 1'b0;
                    chip_cnt_d  = '0;
                    chip_idx_d  = '0;
                    bit_cnt_d   = '0;
                    lfsr_d      = PN_SEED;
                    hold_full_d = 1'b0;
                    fetched_d   = '0;
                    cur_bit_d   = 1'b0;
                end
            end
            S_PREAMBLE, S_PAYLOAD: begin
                if (chip_cnt != DIV_W'(CHIP_DIV - 1)) begin
                    chip_cnt_d = chip_cnt + DIV_W'(1);
                end else begin
                    chip_cnt_d = '0;
                    if (chip_idx != IDX_W'(CHIPS_PER_BIT - 1)) begin
                        chip_idx_d = chip_idx + IDX_W'(1);
                        lfsr_d     = {lfsr[2:0], lfsr[3] ^ lfsr[0]};
                    end else begin
                        // bit boundary: restart the PN period for the next bit
                        chip_idx_d = '0;
                        lfsr_d     = PN_SEED;
                        if (state == S_PREAMBLE) begin
                            if (bit_nxt == CNT_W'(PREAMBLE_BITS)) begin
                                bit_cnt_d = '0;
                                if (len != '0) begin
                                    state_d = S_PAYLOAD;
                                    consume = 1'b1;
                                end else begin
                                    state_d = S_DONE;
                                end
                            end else begin
                                bit_cnt_d = bit_nxt;
                            end
                        end else if (bit_nxt == CNT_W'(len)) begin
                            state_d = S_DONE;
                        end else begin
                            bit_cnt_d = bit_nxt;
                            consume   = 1'b1;
                        end
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef DSSS_TX_ABORT_EN
        if (abort && (state == S_PREAMBLE || state == S_PAYLOAD)) begin
            abort_hit = 1'b1;
            state_d   = S_IDLE;
            consume   = 1'b0;
        end
`endif

        // an empty holding register at a payload boundary still burns a frame slot
        if (consume) begin
            hold_full_d = 1'b0;
            if (hold_full) begin
                cur_bit_d = hold_bit;
            end else begin
                cur_bit_d  = 1'b0;
                underrun_d = 1'b1;
                fetched_d  = fetched_d + FET_W'(1);
            end
        end
        if (xfer) begin
            hold_full_d = 1'b1;
            hold_bit_d  = bit_data;
            fetched_d   = fetched_d + FET_W'(1);
        end

        active_d = (state_d == S_PREAMBLE) || (state_d == S_PAYLOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            chip_cnt  <= '0;
            chip_idx  <= '0;
            bit_cnt   <= '0;
            len       <= '0;
            fetched   <= '0;
            lfsr      <= PN_SEED;
            hold_full <= 1'b0;
            hold_bit  <= 1'b0;
            cur_bit   <= 1'b0;
            underrun  <= 1'b0;
            bit_ready <= 1'b0;
            chip_out  <= 1'b0;
            chip_stb  <= 1'b0;
            mod_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            chip_cnt  <= chip_cnt_d;
            chip_idx  <= chip_idx_d;
            bit_cnt   <= bit_cnt_d;
            len       <= len_d;
            fetched   <= fetched_d;
            lfsr      <= lfsr_d;
            hold_full <= hold_full_d;
            hold_bit  <= hold_bit_d;
            cur_bit   <= cur_bit_d;
            underrun  <= underrun_d;
            bit_ready <= (state_d != S_IDLE) && !hold_full_d && (fetched_d < {1'b0, len_d});
            chip_out  <= active_d && (cur_bit_d ^ lfsr_d[3]);
            chip_stb  <= active_d && (chip_cnt_d == DIV_W'(CHIP_DIV - 1));
            mod_en    <= active_d;
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE);
        end
    end

`ifdef DSSS_TX_ABORT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) aborted <= 1'b0;
        else     aborted <= abort_hit;
    end
`else
    logic unused_abort;
    assign unused_abort = abort_hit;
`endif

endmodule

// File: tb/tb_dsss_tx_sequencer.sv
// Randomized self-checking bench for dsss_tx_sequencer against a frame-time reference model.
module tb_dsss_tx_sequencer;

    localparam int unsigned DIV     = 4;
    localparam int unsigned CPB     = 15;
    localparam int unsigned PRE     = 2;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned BIT_CYC = CPB * DIV;

    logic             clk = 1'b0;
    logic             rst, start, bit_data, bit_valid;
    logic [LEN_W-1:0] frame_len;
    logic             bit_ready, chip_out, chip_stb, mod_en, busy, done, underrun;
`ifdef DSSS_TX_ABORT_EN
    logic             abort = 1'b0;
    logic             aborted;
`endif

    dsss_tx_sequencer #(
        .CHIP_DIV(DIV), .CHIPS_PER_BIT(CPB), .PREAMBLE_BITS(PRE),
        .LEN_W(LEN_W), .PN_SEED(4'b0001)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .bit_data(bit_data), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .chip_out(chip_out), .chip_stb(chip_stb), .mod_en(mod_en),
        .busy(busy), .done(done), .underrun(underrun)
`ifdef DSSS_TX_ABORT_EN
        , .abort(abort), .aborted(aborted)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int pn [CPB] = '{0,0,0,1,1,1,1,0,1,0,1,1,0,0,1};

    // reference model: 0 idle, 1 transmitting, 2 done; m_t = cycles since entering preamble
    int m_state, m_t, m_len, m_claimed;
    bit m_hold, m_hbit, m_cur, m_und;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            if (n_bad <= 20)
                $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return (m_state != 0) && !m_hold && (m_claimed < m_len);
    endfunction

    task automatic model_reset();
        m_state = 0; m_t = 0; m_len = 0; m_claimed = 0;
        m_hold = 0; m_hbit = 0; m_cur = 0; m_und = 0;
    endtask

    task automatic check_outputs();
        bit run;
        int chip;
        bit e_chip, e_stb;
        run    = (m_state == 1);
        chip   = m_t / DIV;
        e_chip = run ? ((((chip / CPB) >= PRE) ? m_cur : 1'b0) ^ pn[chip % CPB][0]) : 1'b0;
        e_stb  = run && ((m_t % DIV) == DIV - 1);
        check_val("mod_en",    mod_en,    run);
        check_val("busy",      busy,      m_state != 0);
        check_val("done",      done,      m_state == 2);
        check_val("chip_out",  chip_out,  e_chip);
        check_val("chip_stb",  chip_stb,  e_stb);
        check_val("bit_ready", bit_ready, model_ready());
        check_val("underrun",  underrun,  m_und);
    endtask

    task automatic step_model(input bit st, input bit v, input bit d, input int fl);
        bit xfer;
        int total;
        xfer = v && model_ready();
        case (m_state)
            0: if (st) begin
                m_state = 1; m_t = 0; m_len = fl; m_und = 0;
                m_claimed = 0; m_hold = 0; m_cur = 0;
            end
            1: begin
                total = (PRE + m_len) * BIT_CYC;
                if (m_t == total - 1) begin
                    m_state = 2;
                end else if (((m_t + 1) % BIT_CYC) == 0 && ((m_t + 1) / BIT_CYC) >= PRE) begin
                    if (m_hold) begin
                        m_cur = m_hbit;
                        m_hold = 0;
                    end else begin
                        m_cur = 0;
                        m_und = 1;
                        m_claimed++;
                    end
                end
                m_t++;
            end
            default: m_state = 0;
        endcase
        if (xfer) begin
            m_hold = 1; m_hbit = d; m_claimed++;
        end
    endtask

    // called just after a falling edge: check, drive the next inputs, advance the model
    task automatic cycle(input bit st, input bit v, input bit d, input int fl);
        check_outputs();
        start = st; bit_valid = v; bit_data = d; frame_len = LEN_W'(fl);
        step_model(st, v, d, fl);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_data = 1'b0; frame_len = '0;
        model_reset();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        @(negedge clk);
    endtask

    // vmode: 0 never valid, 1 always valid, 2 random valid/data
    task automatic run_frame(input int len, input int vmode, input int rst_after, input logic [7:0] pat);
        int n;
        bit v, d, st;
        cycle(1'b1, 1'b0, 1'b0, len);
        n = 0;
        while (m_state != 0 && n < 5000) begin
            if (rst_after > 0 && n == rst_after) begin
                do_reset();
                break;
            end
            v  = (vmode == 1) || (vmode == 2 && $urandom_range(0, 3) == 0);
            d  = (vmode == 2) ? 1'($urandom_range(0, 1)) : pat[m_claimed % 8];
            st = ($urandom_range(0, 15) == 0);
            cycle(st, v, d, int'($urandom_range(0, 255)));
            n++;
        end
        if (n >= 5000) check_val("frame_timeout", busy, 0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_data = 1'b0; frame_len = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;
        @(negedge clk);
        repeat (8) cycle(1'b0, 1'b0, 1'b0, 0);

        run_frame(3, 1, 0, 8'b0000_0101);
        run_frame(2, 0, 0, 8'h00);
        run_frame(0, 2, 0, 8'h00);
        run_frame(3, 1, 150, 8'b0000_0101);
        run_frame(3, 1, 0, 8'b0000_0101);
        repeat (8) run_frame(int'($urandom_range(0, 6)), 2, 0, 8'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
